// File: rtl/psum_collector_pkg.sv
// Shared constants, FSM state type and lane arithmetic helpers for psum_collector.
// Helpers are sized to the default lane geometry.
package psum_collector_pkg;

   localparam int DEF_LANES  = 48;
   localparam int DEF_PSUM_W = 18;
   localparam int DEF_ACC_W  = 24;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [0:0] {
      IDLE,
      ACCUM
   } state_t;

   function automatic logic [DEF_PSUM_W-1:0] lane_of(
      input logic [DEF_LANES*DEF_PSUM_W-1:0] v,
      input int                              i
   );
      return v[i*DEF_PSUM_W +: DEF_PSUM_W];
   endfunction

   function automatic logic [DEF_ACC_W-1:0] sext(
      input logic [DEF_PSUM_W-1:0] x
   );
      return {{(DEF_ACC_W-DEF_PSUM_W){x[DEF_PSUM_W-1]}}, x};
   endfunction

   // Returns {clamped, result}; the extra top bit detects signed overflow.
   function automatic logic [DEF_ACC_W:0] sat_add(
      input logic [DEF_ACC_W-1:0] a,
      input logic [DEF_ACC_W-1:0] b
   );
      logic [DEF_ACC_W:0] s;
      s = {a[DEF_ACC_W-1], a} + {b[DEF_ACC_W-1], b};
      if (s[DEF_ACC_W] != s[DEF_ACC_W-1])
         return {1'b1, s[DEF_ACC_W], {(DEF_ACC_W-1){~s[DEF_ACC_W]}}};
      return {1'b0, s[DEF_ACC_W-1:0]};
   endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Partial-sum input and tile output bundle of psum_collector.
// master: adder tree / output writer side; slave: the collector.
interface psum_collector_if
   import psum_collector_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
);

   logic                    Psum_valid;
   logic [LANES*PSUM_W-1:0] Psum;
   logic [LEN_W-1:0]        acc_len;
   logic                    out_valid;
   logic [LANES*ACC_W-1:0]  out_data;
   logic                    out_ready;

   modport master (
      output Psum_valid, Psum, acc_len, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  Psum_valid, Psum, acc_len, out_ready,
      output out_valid, out_data
   );

endinterface

// File: rtl/psum_tile_fifo.sv
// Register FIFO of completed tiles (DEPTH entries, power of two).
// Ports: push/push_data, pop, rd_data (head, 0 when empty), count, full, empty.
module psum_tile_fifo #(
   parameter int W     = 1152,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  rd_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/psum_collector.sv
// Accumulates acc_len Psum beats per tile into signed lanes and queues tiles.
// Ports: clk, rst, bus (slave), almost_full, ovf, tile_cnt; sat with PSUM_COLLECTOR_SATURATE_EN.
module psum_collector
   import psum_collector_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   psum_collector_if.slave   bus,
   output logic              almost_full,
   output logic              ovf,
   output logic [15:0]       tile_cnt
`ifdef PSUM_COLLECTOR_SATURATE_EN
   ,
   output logic              sat
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = LANES * ACC_W;

   state_t           state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_nxt;
   logic [LEN_W-1:0] len_in;
   logic [TW-1:0]    acc;
   logic [TW-1:0]    sum_flat;
   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] add;
   logic [ACC_W-1:0] lane_sum;
   logic             last;
   logic             complete;
   logic             pop;
   logic             push;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
`ifdef PSUM_COLLECTOR_SATURATE_EN
   logic [LANES-1:0] clamp;
`endif

   assign len_in  = (bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len;
   assign cnt_nxt = cnt + LEN_W'(1);
   assign last    = (state == IDLE) ? (len_in == LEN_W'(1))
                                    : (cnt_nxt == len);
   assign complete = bus.Psum_valid && last;
   assign pop      = bus.out_valid && bus.out_ready;
   assign push     = complete && (!fifo_full || pop);
   assign drop     = complete && fifo_full && !pop;

   // First beat of a tile adds onto zero, so single-beat tiles and
   // the start of multi-beat tiles share one datapath.
   always_comb begin
      sum_flat = '0;
      base     = '0;
      add      = '0;
      lane_sum = '0;
`ifdef PSUM_COLLECTOR_SATURATE_EN
      clamp    = '0;
`endif
      for (int i = 0; i < LANES; i++) begin
         base = (state == ACCUM) ? acc[i*ACC_W +: ACC_W] : '0;
         add  = sext(lane_of(bus.Psum, i));
`ifdef PSUM_COLLECTOR_SATURATE_EN
         {clamp[i], lane_sum} = sat_add(base, add);
`else
         lane_sum = base + add;
`endif
         sum_flat[i*ACC_W +: ACC_W] = lane_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len      <= '0;
         cnt      <= '0;
         acc      <= '0;
         ovf      <= 1'b0;
         tile_cnt <= '0;
`ifdef PSUM_COLLECTOR_SATURATE_EN
         sat      <= 1'b0;
`endif
      end else begin
         if (bus.Psum_valid) begin
            unique case (state)
               IDLE: begin
                  len <= len_in;
                  cnt <= LEN_W'(1);
                  if (!last) begin
                     acc   <= sum_flat;
                     state <= ACCUM;
                  end
               end
               ACCUM: begin
                  cnt <= cnt_nxt;
                  if (last)
                     state <= IDLE;
                  else
                     acc <= sum_flat;
               end
               default: state <= IDLE;
            endcase
         end
         if (complete)
            tile_cnt <= tile_cnt + 16'd1;
         if (drop)
            ovf <= 1'b1;
`ifdef PSUM_COLLECTOR_SATURATE_EN
         if (bus.Psum_valid && |clamp)
            sat <= 1'b1;
`endif
      end
   end

   psum_tile_fifo #(
      .W     (TW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (sum_flat),
      .pop       (pop),
      .rd_data   (bus.out_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.out_valid = !fifo_empty;
   assign almost_full   = (fifo_count >= CW'(DEPTH - 1));

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Receiving end of the adder-tree partial-sum interface (Psum_valid / Psum).
- Consumes per-cycle Psum beats and accumulates a configurable number of beats per output tile (input-channel / weight-round passes) into wide signed lanes.
- Queues completed tiles in a small FIFO and drains them to the output-buffer writer over a valid/ready handshake.

Parameters:
- LANES, 48, number of partial-sum lanes per Psum beat
- PSUM_W, 18, signed width of one Psum lane (LANES*PSUM_W = 864)
- ACC_W, 24, signed accumulator width per lane
- DEPTH, 4, completed-tile FIFO depth (power of two)
- LEN_W, 8, width of acc_len

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- Psum_valid  in  1  beat strobe from adder tree; no backpressure, a beat is accepted every cycle it is high
- Psum  in  LANES*PSUM_W  beat; lane i = bits [i*PSUM_W +: PSUM_W], signed
- acc_len  in  LEN_W  beats per tile; sampled on the first beat of a tile; 0 treated as 1
- out_valid  out  1  FIFO head valid
- out_data  out  LANES*ACC_W  FIFO head tile; lane i = bits [i*ACC_W +: ACC_W]
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- almost_full  out  1  FIFO count >= DEPTH-1
- ovf  out  1  sticky: a completed tile was dropped
- tile_cnt  out  16  completed tiles pushed, wraps at 2^16

Behaviour:
- Reset: state IDLE; acc lanes, beat counter, FIFO pointers and count cleared; out_valid=0, out_data=0, almost_full=0, ovf=0, tile_cnt=0. A reset mid-tile discards the partial tile and all queued tiles.
- FSM IDLE:
  - Psum_valid=1: latch len = max(acc_len,1) and set beat counter to 1.
  - If len==1: complete the tile this cycle.
  - Else: acc = sign-extended Psum, go to ACCUM.
- FSM ACCUM:
  - Each Psum_valid: counter+1, per-lane sum = acc + sext(lane).
  - When the counter reaches len: complete the tile, go to IDLE.
  - Otherwise the sum is written to acc.
  - Psum_valid=0 holds all state; gaps between beats are legal.
- Completion: the tile pushes the combinational final sum (not the registered acc) into the FIFO on the completing edge; tile_cnt+1.
  - Latency: last beat at edge N gives out_valid=1 after edge N when the FIFO was empty.
- Arithmetic: per-lane two's complement. Lane sum wraps modulo 2^ACC_W. No cross-lane carry.
- FIFO:
  - Pop on out_valid & out_ready.
  - out_data is stable while out_valid & !out_ready.
  - Push when completing and (count<DEPTH or pop in same cycle).
  - Full with no pop: the tile is dropped, ovf=1 until rst, and tile_cnt still increments.
- Simultaneous push and pop at any count: count unchanged, order preserved.
- acc_len changes mid-tile: ignored until the next tile starts.

Optional Feature:
- Macro: PSUM_COLLECTOR_SATURATE_EN.
- Defined: each lane addition clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Adds an output port sat (1 bit), sticky, set on any clamp, cleared only by rst.
- Undefined: wrap-around arithmetic and no sat port.

Decomposition:
- Shared package: LANES, PSUM_W, ACC_W, DEPTH defaults; FSM state enum (IDLE, ACCUM); lane slice/sign-extend functions; saturating-add function.
- One sub-module: psum_tile_fifo. It is a DEPTH x LANES*ACC_W register FIFO with push, pop, count, full and empty. It is instantiated once.

Test Plan:
- acc_len=1, one beat with all lanes = 5 -> out_valid next cycle, every lane 5, tile_cnt=1.
- acc_len=3, lane0 beats 100, -30, 7 with other lanes 1; one idle cycle between beats 2 and 3 -> exactly one tile; lane0 = 77, others = 3; no out_valid before the third beat.
- acc_len=64, all lanes -131072 -> every lane -8388608. With acc_len=65 -> 8257536 (wrap). With PSUM_COLLECTOR_SATURATE_EN -> -8388608 and sat=1.
- DEPTH=4, out_ready=0, five acc_len=1 tiles with values 1..5:
  - almost_full rises after tile 3.
  - Tile 5 is dropped with ovf=1.
  - Then out_ready=1 drains 1, 2, 3, 4 in order.
- FIFO full, fifth tile completes in the same cycle out_ready=1 pops -> no ovf; drained order 2, 3, 4, 5.
- acc_len=3, assert rst after beat 2 -> out_valid=0, tile_cnt=0. A following single-beat tile of value 9 outputs 9 with no residue from the aborted tile.
